// File: rtl/branch_target_table.sv
// Programmable branch target table: DEPTH entries of {vld, abs, offset},
// cleared by a one-entry-per-cycle sweep, with a one-cycle registered lookup.
module branch_target_table #(
  parameter int PTR_W = 5,
  parameter int PC_W  = 8,
  parameter int DEPTH = 32
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_ptr,
  input  logic [PC_W-1:0]  wr_offset,
  input  logic             wr_abs,
  input  logic             rd_req,
  input  logic [PTR_W-1:0] rd_ptr,
  input  logic [PC_W-1:0]  pc_in,
  output logic             busy,
  output logic             rd_valid,
  output logic [PC_W-1:0]  target,
  output logic             hit,
  output logic             is_abs
);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  // One extra bit so DEPTH == 2**PTR_W is representable.
  localparam logic [PTR_W:0]   DEPTH_L  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

  state_t           r_state;
  state_t           w_state_nx;
  logic [PTR_W-1:0] r_idx;
  logic [PTR_W-1:0] w_idx_nx;
  logic             r_busy;

  logic             r_vld [0:DEPTH-1];
  logic             r_abs [0:DEPTH-1];
  logic [PC_W-1:0]  r_off [0:DEPTH-1];

  logic             r_rd_valid;
  logic [PC_W-1:0]  r_target;
  logic             r_hit;
  logic             r_is_abs;

  logic             w_wr_in_range;
  logic             w_rd_in_range;
  logic             w_run_ok;
  logic             w_wr_fire;
  logic             w_rd_fire;
  logic             w_bypass;
  logic [PTR_W-1:0] w_rd_idx;
  logic             w_e_vld;
  logic             w_e_abs;
  logic [PC_W-1:0]  w_e_off;
  logic [PC_W-1:0]  w_tgt;
  logic             w_hit;
  logic             w_is_abs;

  assign w_wr_in_range = ({1'b0, wr_ptr} < DEPTH_L);
  assign w_rd_in_range = ({1'b0, rd_ptr} < DEPTH_L);
  // clr in RUN drops any access issued in the same cycle.
  assign w_run_ok      = (r_state == ST_RUN) && !clr;
  assign w_wr_fire     = w_run_ok && wr_en && w_wr_in_range;
  assign w_rd_fire     = w_run_ok && rd_req;
  assign w_bypass      = w_wr_fire && (wr_ptr == rd_ptr);
  assign w_rd_idx      = w_rd_in_range ? rd_ptr : {PTR_W{1'b0}};

  // Next-state logic for the init sweep / run FSM.
  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    case (r_state)
      ST_INIT: begin
        if (r_idx == LAST_IDX) begin
          w_state_nx = ST_RUN;
          w_idx_nx   = {PTR_W{1'b0}};
        end else begin
          w_state_nx = ST_INIT;
          w_idx_nx   = r_idx + PTR_W'(1);
        end
      end
      ST_RUN: begin
        if (clr) begin
          w_state_nx = ST_INIT;
          w_idx_nx   = {PTR_W{1'b0}};
        end else begin
          w_state_nx = ST_RUN;
          w_idx_nx   = r_idx;
        end
      end
      default: begin
        w_state_nx = ST_INIT;
        w_idx_nx   = {PTR_W{1'b0}};
      end
    endcase
  end

  // FSM state, sweep index and busy flag.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state <= ST_INIT;
      r_idx   <= {PTR_W{1'b0}};
      r_busy  <= 1'b1;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      r_busy  <= (w_state_nx == ST_INIT);
    end
  end

  // Entry storage: sweep clear in INIT, programmed writes in RUN.
  always_ff @(posedge CLK) begin
    if (r_state == ST_INIT) begin
      r_vld[r_idx] <= 1'b0;
      r_abs[r_idx] <= 1'b0;
      r_off[r_idx] <= {PC_W{1'b0}};
    end else if (w_wr_fire) begin
      r_vld[wr_ptr] <= 1'b1;
      r_abs[wr_ptr] <= wr_abs;
      r_off[wr_ptr] <= wr_offset;
    end
  end

  // Entry selection with write-first bypass, then target resolution.
  always_comb begin
    w_e_vld  = r_vld[w_rd_idx];
    w_e_abs  = r_abs[w_rd_idx];
    w_e_off  = r_off[w_rd_idx];
    w_tgt    = pc_in + PC_W'(1);
    w_hit    = 1'b0;
    w_is_abs = 1'b0;
    if (w_bypass) begin
      w_e_vld = 1'b1;
      w_e_abs = wr_abs;
      w_e_off = wr_offset;
    end else begin
      w_e_vld = w_e_vld & w_rd_in_range;
    end
    // Equal-width add is the sign-extended add modulo 2**PC_W.
    if (w_e_vld) begin
      w_hit = 1'b1;
      if (w_e_abs) begin
        w_tgt    = w_e_off;
        w_is_abs = 1'b1;
      end else begin
        w_tgt    = pc_in + w_e_off;
        w_is_abs = 1'b0;
      end
    end else begin
      w_hit = 1'b0;
    end
  end

  // Registered lookup result; holds its value between valid pulses.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
      r_target   <= {PC_W{1'b0}};
      r_hit      <= 1'b0;
      r_is_abs   <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_fire;
      if (w_rd_fire) begin
        r_target <= w_tgt;
        r_hit    <= w_hit;
        r_is_abs <= w_is_abs;
      end else begin
        r_target <= r_target;
        r_hit    <= r_hit;
        r_is_abs <= r_is_abs;
      end
    end
  end

  assign busy     = r_busy;
  assign rd_valid = r_rd_valid;
  assign target   = r_target;
  assign hit      = r_hit;
  assign is_abs   = r_is_abs;

endmodule

// File: tb/tb_branch_target_table.sv
// Drives a DEPTH=32 and a DEPTH=20 table with identical stimulus; a table model
// predicts each lookup into a queue that per-instance monitors pop and compare.
module tb_branch_target_table;

  logic       CLK = 1'b0;
  logic       reset, clr, wr_en, wr_abs, rd_req;
  logic [4:0] wr_ptr, rd_ptr;
  logic [7:0] wr_offset, pc_in;

  logic       a_busy, a_rd_valid, a_hit, a_is_abs;
  logic [7:0] a_target;
  logic       b_busy, b_rd_valid, b_hit, b_is_abs;
  logic [7:0] b_target;

  always #5 CLK = ~CLK;

  branch_target_table #(.PTR_W(5), .PC_W(8), .DEPTH(32)) dut_a (
    .CLK(CLK), .reset(reset), .clr(clr), .wr_en(wr_en), .wr_ptr(wr_ptr),
    .wr_offset(wr_offset), .wr_abs(wr_abs), .rd_req(rd_req), .rd_ptr(rd_ptr),
    .pc_in(pc_in), .busy(a_busy), .rd_valid(a_rd_valid), .target(a_target),
    .hit(a_hit), .is_abs(a_is_abs));

  branch_target_table #(.PTR_W(5), .PC_W(8), .DEPTH(20)) dut_b (
    .CLK(CLK), .reset(reset), .clr(clr), .wr_en(wr_en), .wr_ptr(wr_ptr),
    .wr_offset(wr_offset), .wr_abs(wr_abs), .rd_req(rd_req), .rd_ptr(rd_ptr),
    .pc_in(pc_in), .busy(b_busy), .rd_valid(b_rd_valid), .target(b_target),
    .hit(b_hit), .is_abs(b_is_abs));

  typedef struct packed {logic [7:0] t; logic h; logic a;} res_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  bit         mon_en   = 1'b0;
  res_t       q_a[$];
  res_t       q_b[$];
  res_t       hold [2];
  bit         m_vld [2][32];
  bit         m_abs [2][32];
  logic [7:0] m_off [2][32];
  int         busy_left [2];
  int         depth [2] = '{32, 20};

  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (DEPTH=%0d) at %0t: got %0d, expected %0d", nm, depth[k], $time, act, exp);
    end
  endtask

  function automatic void clear_table(int k);
    for (int i = 0; i < 32; i++) begin
      m_vld[k][i] = 1'b0;
      m_abs[k][i] = 1'b0;
      m_off[k][i] = 8'd0;
    end
  endfunction

  // Effect of one rising edge on the model of table k, given current inputs.
  function automatic void model_edge(int k);
    res_t e;
    int   s;
    if (reset) begin
      busy_left[k] = depth[k];
      clear_table(k);
      if (k == 0) q_a.delete(); else q_b.delete();
      hold[k] = '0;
    end else if (busy_left[k] > 0) begin
      busy_left[k]--;
    end else if (clr) begin
      busy_left[k] = depth[k];
      clear_table(k);
    end else begin
      if (wr_en && int'(wr_ptr) < depth[k]) begin
        m_vld[k][wr_ptr] = 1'b1;
        m_abs[k][wr_ptr] = wr_abs;
        m_off[k][wr_ptr] = wr_offset;
      end
      if (rd_req) begin
        if (int'(rd_ptr) < depth[k] && m_vld[k][rd_ptr]) begin
          if (m_abs[k][rd_ptr]) begin
            e.t = m_off[k][rd_ptr];
            e.a = 1'b1;
          end else begin
            s   = int'($signed(m_off[k][rd_ptr]));
            e.t = 8'((int'(pc_in) + s + 256) % 256);
            e.a = 1'b0;
          end
          e.h = 1'b1;
        end else begin
          e.t = 8'((int'(pc_in) + 1) % 256);
          e.h = 1'b0;
          e.a = 1'b0;
        end
        if (k == 0) q_a.push_back(e); else q_b.push_back(e);
      end
    end
  endfunction

  task automatic mon(int k, logic v, logic [7:0] t, logic h, logic a, logic b);
    res_t e;
    int   qs;
    qs = (k == 0) ? q_a.size() : q_b.size();
    chk("busy", k, 32'(b), 32'(busy_left[k] > 0));
    if (v === 1'b1) begin
      if (qs == 0) begin
        chk("unexpected_rd_valid", k, 32'(v), 32'd0);
      end else begin
        if (k == 0) e = q_a.pop_front(); else e = q_b.pop_front();
        chk("target", k, 32'(t), 32'(e.t));
        chk("hit", k, 32'(h), 32'(e.h));
        chk("is_abs", k, 32'(a), 32'(e.a));
        hold[k] = e;
      end
    end else begin
      chk("missing_rd_valid", k, 32'(qs), 32'd0);
      chk("held_target", k, 32'(t), 32'(hold[k].t));
      chk("held_hit", k, 32'(h), 32'(hold[k].h));
      chk("held_is_abs", k, 32'(a), 32'(hold[k].a));
    end
  endtask

  always @(negedge CLK) if (mon_en) mon(0, a_rd_valid, a_target, a_hit, a_is_abs, a_busy);
  always @(negedge CLK) if (mon_en) mon(1, b_rd_valid, b_target, b_hit, b_is_abs, b_busy);

  task automatic step(bit rs, bit cl, bit we, logic [4:0] wp, logic [7:0] wo, bit wa,
                      bit rr, logic [4:0] rp, logic [7:0] pc);
    reset = rs; clr = cl; wr_en = we; wr_ptr = wp; wr_offset = wo; wr_abs = wa;
    rd_req = rr; rd_ptr = rp; pc_in = pc;
    @(posedge CLK);
    model_edge(0);
    model_edge(1);
    @(negedge CLK);
  endtask

  task automatic rd(logic [4:0] p, logic [7:0] pc);
    step(0, 0, 0, 5'd0, 8'd0, 0, 1, p, pc);
  endtask

  task automatic wr(logic [4:0] p, logic [7:0] o, bit a);
    step(0, 0, 1, p, o, a, 0, 5'd0, 8'd0);
  endtask

  initial begin
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) step(1, 0, 0, 5'd0, 8'd0, 0, 1, 5'd3, 8'd40);
    // Reset again at sweep index 10 with rd_req held high.
    for (int i = 0; i < 10; i++) step(0, 0, 0, 5'd0, 8'd0, 0, 1, 5'd3, 8'd40);
    step(1, 0, 0, 5'd0, 8'd0, 0, 1, 5'd3, 8'd40);
    for (int i = 0; i < 36; i++) step(0, 0, 0, 5'd0, 8'd0, 0, 1, 5'd3, 8'd40);
    rd(5'd3, 8'd40);
    wr(5'd1, 8'hF5, 0);  rd(5'd1, 8'd20);
    wr(5'd2, 8'd6, 1);   rd(5'd2, 8'd100);
    wr(5'd4, 8'd10, 0);  rd(5'd4, 8'd250);
    wr(5'd5, 8'hEE, 0);  rd(5'd5, 8'd5);
    step(0, 0, 1, 5'd7, 8'd15, 0, 1, 5'd7, 8'd0);
    rd(5'd1, 8'd20);
    rd(5'd7, 8'd0);
    wr(5'd25, 8'd3, 0);  rd(5'd25, 8'd7);
    step(0, 1, 1, 5'd9, 8'd9, 0, 1, 5'd1, 8'd20);
    for (int i = 0; i < 34; i++) step(0, 0, 0, 5'd0, 8'd0, 0, 0, 5'd0, 8'd0);
    for (int i = 0; i < 32; i++) rd(5'(i), 8'($urandom_range(0, 255)));
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] wp;
      wp = 5'($urandom_range(0, 31));
      step($urandom_range(0, 399) == 0, $urandom_range(0, 149) == 0,
           $urandom_range(0, 1) == 1, wp, 8'($urandom_range(0, 255)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 7,
           ($urandom_range(0, 3) == 0) ? wp : 5'($urandom_range(0, 31)),
           8'($urandom_range(0, 255)));
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 5'd0, 8'd0, 0, 0, 5'd0, 8'd0);
    chk("drain", 0, 32'(q_a.size()), 32'd0);
    chk("drain", 1, 32'(q_b.size()), 32'd0);
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
